// File: rtl/row_uram_arbiter_pkg.sv
// Shared types and constants for the row-level URAM arbiter and its helpers.
//   arb_state_t       : arbiter FSM states
//   DEFAULT_NUM_CORES : default channel count of a row
//   ARB_IDX_W         : channel index width for the default row size
//   EPOCH_W           : width of the completed-epoch counter
//   idx_width()       : index width for an arbitrary channel count (never 0)
package row_uram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED,
        FLUSH
    } arb_state_t;

    localparam int DEFAULT_NUM_CORES = 8;
    localparam int ARB_IDX_W         = $clog2(DEFAULT_NUM_CORES);
    localparam int EPOCH_W           = 8;

    // A single-channel row still needs a 1-bit index, so clamp the width at 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_uram_arbiter_picker.sv
// rr_priority_picker: combinational winner selection over a request vector.
//   req        : candidate requests (already filtered by the caller)
//   ptr        : index of the last winner; round-robin search starts at ptr+1
//   rr_mode    : 1 = round-robin from ptr+1 (mod N), 0 = lowest index wins
//   winner     : one-hot winner, zero when no request is set
//   winner_idx : binary index of the winner
//   valid      : at least one request was set
module rr_priority_picker
    import row_uram_arbiter_pkg::*;
#(
    parameter int N     = DEFAULT_NUM_CORES,
    parameter int IDX_W = ARB_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    // Walk the candidates in search order and keep the first hit. The modulo
    // keeps the rotation correct for channel counts that are not powers of two.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] k;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        pos        = 0;
        k          = '0;
        for (int i = 0; i < N; i++) begin
            pos = rr_mode ? ((int'(ptr) + 1 + i) % N) : i;
            k   = IDX_W'(pos);
            if (!valid && req[k]) begin
                valid      = 1'b1;
                winner_idx = k;
            end
        end
        if (valid) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/row_uram_arbiter.sv
// row_uram_arbiter: grants one core of a row exclusive use of the shared URAM,
// muxes that core's port onto the physical URAM, and runs the per-epoch barrier
// (every enabled core served once, then drain, then broadcast release).
//   clk, reset            : clock, asynchronous active-high reset
//   i_core_req/locked     : per-core request and lock-held flags
//   o_core_grant          : registered one-hot grant
//   i_uram_*              : packed per-core URAM ports (core k at slice k)
//   o_uram_*              : physical URAM port
//   o_flush_req/i_flush_done : handshake with the drain engine
//   o_uram_emptied        : one-cycle barrier release pulse
//   o_epoch               : completed-epoch counter
module row_uram_arbiter
    import row_uram_arbiter_pkg::*;
#(
    parameter int                   NUM_CORES     = 8,
    parameter int                   ADDR_W        = 12,
    parameter int                   DATA_W        = 32,
    parameter logic [NUM_CORES-1:0] CORE_MASK     = '1,
    parameter bit                   RR_MODE       = 1'b1,
    parameter int                   GRANT_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        i_core_req,
    input  logic [NUM_CORES-1:0]        i_core_locked,
    output logic [NUM_CORES-1:0]        o_core_grant,
    input  logic [NUM_CORES-1:0]        i_uram_en,
    input  logic [NUM_CORES*ADDR_W-1:0] i_uram_addr,
    input  logic [NUM_CORES*DATA_W-1:0] i_uram_wr_data,
    input  logic [NUM_CORES-1:0]        i_uram_wr_en,
    output logic                        o_uram_en,
    output logic [ADDR_W-1:0]           o_uram_addr,
    output logic [DATA_W-1:0]           o_uram_wr_data,
    output logic                        o_uram_wr_en,
    output logic                        o_flush_req,
    input  logic                        i_flush_done,
    output logic                        o_uram_emptied,
    output logic [EPOCH_W-1:0]          o_epoch
);

    localparam int IDX_W   = idx_width(NUM_CORES);
    localparam int TIMER_W = idx_width(GRANT_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(GRANT_TIMEOUT - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_CORES-1:0]   served;
    logic [TIMER_W-1:0]     timer;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    // Cores already served this epoch and masked-out cores never compete.
    assign eligible = i_core_req & CORE_MASK & ~served;

    rr_priority_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (eligible),
        .ptr        (rr_ptr),
        .rr_mode    (RR_MODE),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Arbitration FSM. The grant and barrier outputs are registered here so
    // the cores never see a combinational glitch on their grant line. A core
    // that times out or withdraws its request is not marked served and may be
    // granted again later in the same epoch; a timeout also moves the
    // round-robin pointer past it so it cannot starve its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            o_core_grant   <= '0;
            grant_idx      <= '0;
            rr_ptr         <= '0;
            served         <= '0;
            timer          <= '0;
            o_flush_req    <= 1'b0;
            o_uram_emptied <= 1'b0;
            o_epoch        <= '0;
        end else begin
            o_uram_emptied <= 1'b0;
            case (state)
                IDLE: begin
                    if (served == CORE_MASK) begin
                        state       <= FLUSH;
                        o_flush_req <= 1'b1;
                    end else if (pick_valid) begin
                        o_core_grant <= pick_onehot;
                        grant_idx    <= pick_idx;
                        timer        <= '0;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (i_core_locked[grant_idx]) begin
                        timer <= '0;
                        state <= LOCKED;
                    end else if (!i_core_req[grant_idx]) begin
                        o_core_grant <= '0;
                        state        <= IDLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        o_core_grant <= '0;
                        rr_ptr       <= grant_idx;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!i_core_locked[grant_idx]) begin
                        o_core_grant      <= '0;
                        served[grant_idx] <= 1'b1;
                        rr_ptr            <= grant_idx;
                        state             <= IDLE;
                    end
                end
                FLUSH: begin
                    if (i_flush_done) begin
                        o_flush_req    <= 1'b0;
                        o_uram_emptied <= 1'b1;
                        served         <= '0;
                        o_epoch        <= o_epoch + 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // URAM port mux driven only from registered state, so an asynchronous
    // reset removes the granted core from the URAM in the same cycle.
    always_comb begin
        o_uram_en      = 1'b0;
        o_uram_addr    = '0;
        o_uram_wr_data = '0;
        o_uram_wr_en   = 1'b0;
        if (state == GRANT || state == LOCKED) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (o_core_grant[k]) begin
                    o_uram_en      = i_uram_en[k];
                    o_uram_addr    = i_uram_addr[k*ADDR_W +: ADDR_W];
                    o_uram_wr_data = i_uram_wr_data[k*DATA_W +: DATA_W];
                    o_uram_wr_en   = i_uram_wr_en[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Scoreboard bench for row_uram_arbiter. Instance 0 is fixed priority with all
// four cores enabled; instance 1 is round-robin with core 3 masked out.
module tb_row_uram_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct { int inst; int idx; int dur; } exp_grant_t;
    typedef struct { int inst; int epoch; } exp_epoch_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req      [2];
    logic [N-1:0]    locked   [2];
    logic [N-1:0]    grant    [2];
    logic [N-1:0]    en       [2];
    logic [N-1:0]    wr_en    [2];
    logic [N*AW-1:0] addr     [2];
    logic [N*DW-1:0] wdata    [2];
    logic            u_en     [2];
    logic [AW-1:0]   u_addr   [2];
    logic [DW-1:0]   u_data   [2];
    logic            u_wr     [2];
    logic            flush_req  [2];
    logic            flush_done [2];
    logic            emptied    [2];
    logic [7:0]      epoch      [2];

    logic [AW-1:0] addr_tab [N] = '{12'hFFF, 12'h011, 12'h123, 12'h3A5};
    logic [DW-1:0] data_tab [N] = '{32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    logic [N-1:0]  wr_tab = 4'b0111;

    int checks = 0;
    int errors = 0;

    exp_grant_t gq [$];
    exp_epoch_t eq [$];

    int         hold [2][N];
    int         skip [2][N];
    int         cnt  [2][N];
    logic [N-1:0] prev_g [2];
    int         fcnt [2];

    logic       in_g      [2];
    int         dur       [2];
    exp_grant_t cur       [2];
    logic       prev_done [2];

    row_uram_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW),
        .CORE_MASK(4'b1111), .RR_MODE(1'b0), .GRANT_TIMEOUT(16)
    ) u_dut_fixed (
        .clk(clk), .reset(reset),
        .i_core_req(req[0]), .i_core_locked(locked[0]), .o_core_grant(grant[0]),
        .i_uram_en(en[0]), .i_uram_addr(addr[0]), .i_uram_wr_data(wdata[0]),
        .i_uram_wr_en(wr_en[0]),
        .o_uram_en(u_en[0]), .o_uram_addr(u_addr[0]), .o_uram_wr_data(u_data[0]),
        .o_uram_wr_en(u_wr[0]),
        .o_flush_req(flush_req[0]), .i_flush_done(flush_done[0]),
        .o_uram_emptied(emptied[0]), .o_epoch(epoch[0])
    );

    row_uram_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW),
        .CORE_MASK(4'b0111), .RR_MODE(1'b1), .GRANT_TIMEOUT(16)
    ) u_dut_rr (
        .clk(clk), .reset(reset),
        .i_core_req(req[1]), .i_core_locked(locked[1]), .o_core_grant(grant[1]),
        .i_uram_en(en[1]), .i_uram_addr(addr[1]), .i_uram_wr_data(wdata[1]),
        .i_uram_wr_en(wr_en[1]),
        .o_uram_en(u_en[1]), .o_uram_addr(u_addr[1]), .o_uram_wr_data(u_data[1]),
        .o_uram_wr_en(u_wr[1]),
        .o_flush_req(flush_req[1]), .i_flush_done(flush_done[1]),
        .o_uram_emptied(emptied[1]), .o_epoch(epoch[1])
    );

    // Single comparison point: every check in the bench funnels through here.
    task automatic check_output(input string name, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d got=0x%0h expected=0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name, input int inst, input logic [63:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s inst=%0d got=0x%0h expected=nothing", name, inst, act);
    endtask

    task automatic push_grant(input int inst, input int idx, input int d);
        exp_grant_t e;
        e.inst = inst; e.idx = idx; e.dur = d;
        gq.push_back(e);
    endtask

    task automatic push_epoch(input int inst, input int ep);
        exp_epoch_t e;
        e.inst = inst; e.epoch = ep;
        eq.push_back(e);
    endtask

    task automatic apply_stimulus(input int inst, input logic [N-1:0] bits);
        req[inst] = req[inst] | bits;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((gq.size() != 0 || eq.size() != 0 || in_g[0] || in_g[1]) && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("[TB] FAIL drain_timeout pending_grants=%0d pending_epochs=%0d expected=0",
                     gq.size(), eq.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Core and drain-engine agent: a granted core locks for hold cycles and
    // then withdraws; a core with skip>0 ignores that many grants (timeout).
    // The drain engine answers a flush request with a one-cycle done pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < N; k++) begin
                        if (locked[i][k]) begin
                            if (cnt[i][k] > 1) cnt[i][k]--;
                            else begin
                                locked[i][k] = 1'b0;
                                req[i][k]    = 1'b0;
                            end
                        end else if (grant[i][k] && req[i][k] && skip[i][k] == 0) begin
                            locked[i][k] = 1'b1;
                            cnt[i][k]    = hold[i][k];
                        end else if (prev_g[i][k] && !grant[i][k] && skip[i][k] > 0) begin
                            skip[i][k]--;
                        end
                    end
                    prev_g[i] = grant[i];
                    if (flush_done[i]) flush_done[i] = 1'b0;
                    else if (flush_req[i]) begin
                        fcnt[i]++;
                        if (fcnt[i] == 2) begin
                            flush_done[i] = 1'b1;
                            fcnt[i]       = 0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a grant rises, a grant falls or
    // the barrier release pulses.
    initial begin
        logic [N-1:0] onehot;
        exp_epoch_t   e;
        for (int i = 0; i < 2; i++) begin
            in_g[i] = 1'b0; dur[i] = 0; prev_done[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    in_g[i] = 1'b0;
                end else if (!in_g[i] && grant[i] != '0) begin
                    in_g[i] = 1'b1;
                    dur[i]  = 1;
                    if (gq.size() == 0 || gq[0].inst != i) begin
                        report_unexpected("unexpected_grant", i, 64'(grant[i]));
                        cur[i].dur = 0;
                    end else begin
                        cur[i] = gq.pop_front();
                        onehot = N'(1) << cur[i].idx;
                        check_output("grant_onehot", i, 64'(grant[i]), 64'(onehot));
                        check_output("uram_en", i, 64'(u_en[i]), 64'(1'b1));
                        check_output("uram_addr", i, 64'(u_addr[i]), 64'(addr_tab[cur[i].idx]));
                        check_output("uram_data", i, 64'(u_data[i]), 64'(data_tab[cur[i].idx]));
                        check_output("uram_wr_en", i, 64'(u_wr[i]), 64'(wr_tab[cur[i].idx]));
                    end
                end else if (in_g[i] && grant[i] == '0) begin
                    in_g[i] = 1'b0;
                    if (cur[i].dur != 0)
                        check_output("grant_cycles", i, 64'(dur[i]), 64'(cur[i].dur));
                    check_output("uram_idle", i, 64'({u_en[i], u_wr[i], u_addr[i], u_data[i]}), 64'(0));
                end else if (in_g[i]) begin
                    dur[i]++;
                end
                if (!reset && emptied[i]) begin
                    if (eq.size() == 0 || eq[0].inst != i) begin
                        report_unexpected("unexpected_emptied", i, 64'(epoch[i]));
                    end else begin
                        e = eq.pop_front();
                        check_output("epoch", i, 64'(epoch[i]), 64'(e.epoch));
                        check_output("done_before_emptied", i, 64'(prev_done[i]), 64'(1'b1));
                        check_output("flush_req_dropped", i, 64'(flush_req[i]), 64'(1'b0));
                    end
                end
                prev_done[i] = flush_done[i];
            end
        end
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; locked[i] = '0; prev_g[i] = '0; fcnt[i] = 0;
            flush_done[i] = 1'b0;
            en[i] = '1; wr_en[i] = wr_tab;
            for (int k = 0; k < N; k++) begin
                addr[i][k*AW +: AW]  = addr_tab[k];
                wdata[i][k*DW +: DW] = data_tab[k];
                hold[i][k] = 3; skip[i][k] = 0; cnt[i][k] = 0;
            end
        end

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("reset_grant", i, 64'(grant[i]), 64'(0));
            check_output("reset_epoch", i, 64'(epoch[i]), 64'(0));
            check_output("reset_flush", i, 64'({flush_req[i], emptied[i]}), 64'(0));
            check_output("reset_uram", i, 64'({u_en[i], u_wr[i], u_addr[i], u_data[i]}), 64'(0));
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Fixed priority, all request at once: 0,1,2,3 then barrier epoch 1.
        for (int k = 0; k < N; k++) push_grant(0, k, 4);
        push_epoch(0, 1);
        apply_stimulus(0, 4'b1111);
        wait_drain(300);

        // Round-robin with core 3 masked: core 1 is granted first (search
        // starts at pointer+1), ignores it and times out after 16 cycles,
        // then 2 and 0 are served and core 1 is granted again.
        skip[1][1] = 1;
        push_grant(1, 1, 16);
        push_grant(1, 2, 4);
        push_grant(1, 0, 4);
        push_grant(1, 1, 4);
        push_epoch(1, 1);
        apply_stimulus(1, 4'b1111);
        wait_drain(300);

        // Fixed priority, req 1010 then 0101 over two epochs: 1 before 3.
        for (int ep = 2; ep <= 3; ep++) begin
            push_grant(0, 1, 4);
            push_grant(0, 3, 4);
            apply_stimulus(0, 4'b1010);
            wait_drain(200);
            push_grant(0, 0, 4);
            push_grant(0, 2, 4);
            push_epoch(0, ep);
            apply_stimulus(0, 4'b0101);
            wait_drain(200);
        end

        // Reset while core 2 holds the lock, with core 0 already served.
        push_grant(0, 0, 4);
        apply_stimulus(0, 4'b0001);
        wait_drain(200);
        hold[0][2] = 20;
        push_grant(0, 2, 0);
        apply_stimulus(0, 4'b0100);
        n = 0;
        while (!(locked[0][2] && grant[0][2]) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("lock_reached", 0, 64'(n < 50), 64'(1'b1));
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("reset_mid_grant", 0, 64'(grant[0]), 64'(0));
        check_output("reset_mid_uram", 0, 64'({u_en[0], u_wr[0], u_addr[0], u_data[0]}), 64'(0));
        check_output("reset_mid_flush", 0, 64'(flush_req[0]), 64'(0));
        req[0] = '0; locked[0] = '0; prev_g[0] = '0;
        for (int k = 0; k < N; k++) begin
            cnt[0][k] = 0; hold[0][k] = 3;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("post_reset_epoch", 0, 64'(epoch[0]), 64'(0));
        check_output("post_reset_epoch_rr", 1, 64'(epoch[1]), 64'(0));
        @(posedge clk);
        #1;
        // Served must have been cleared: core 0 is granted again first.
        for (int k = 0; k < N; k++) push_grant(0, k, 4);
        push_epoch(0, 1);
        apply_stimulus(0, 4'b1111);
        wait_drain(300);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
